// File: rtl/blink_pkg.sv
// ============================================================================
// Module   : blink_pkg
// Brief    : Shared types and defaults for the blink sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package blink_pkg;

    localparam int unsigned c_tick_div = 100_000;
    localparam int unsigned c_speed_w  = 16;
    localparam int unsigned c_dur_w    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [c_speed_w-1:0] speed;
        logic [c_dur_w-1:0]   dur;
    } seq_entry_t;

endpackage

`default_nettype wire

// File: rtl/ms_tick_gen.sv
// ============================================================================
// Module   : ms_tick_gen
// Brief    : Prescaler producing a one-cycle tick every TICK_DIV clocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ms_tick_gen
    import blink_pkg::*;
#(
    parameter int unsigned TICK_DIV = c_tick_div
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned        c_cnt_w = $clog2(TICK_DIV);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TICK_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/blink_sequencer.sv
// ============================================================================
// Module   : blink_sequencer
// Brief    : Plays a table of (blink period, dwell ms) entries into a
//            blink_controller speed input.
// Revision : 1.0
// ============================================================================
`default_nettype none

module blink_sequencer
    import blink_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned SPEED_W  = c_speed_w,
    parameter int unsigned DUR_W    = c_dur_w,
    parameter int unsigned TICK_DIV = c_tick_div
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
    input  logic [SPEED_W-1:0]         cfg_speed,
    input  logic [DUR_W-1:0]           cfg_dur,
    input  logic [$clog2(DEPTH):0]     seq_len,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       stop,
    output logic [SPEED_W-1:0]         speed,
    output logic [$clog2(DEPTH)-1:0]   step,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned     c_aw       = $clog2(DEPTH);
    localparam int unsigned     c_lw       = c_aw + 1;
    localparam logic [c_lw-1:0] c_depth    = c_lw'(DEPTH);
    localparam logic [c_aw-1:0] c_last_idx = c_aw'(DEPTH - 1);

    seq_entry_t          r_table [DEPTH];
    seq_state_e          r_state, w_state_nxt;
    logic [SPEED_W-1:0]  r_speed, w_speed_nxt;
    logic [c_aw-1:0]     r_step, w_step_nxt, w_load_idx;
    logic [DUR_W-1:0]    r_dwell, w_dwell_nxt;
    seq_entry_t          w_entry;
    logic                w_load, w_tick, w_tick_clr, w_len_ok, w_last;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_tick_clr),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_table[i] <= '0;
            end
        end else if (cfg_we && ({1'b0, cfg_addr} < c_depth)) begin
            r_table[cfg_addr] <= '{speed: c_speed_w'(cfg_speed), dur: c_dur_w'(cfg_dur)};
        end
    end

    assign w_len_ok = (seq_len != '0) && (seq_len <= c_depth);
    // A shrunken seq_len or the physical end of the table both end the pass.
    assign w_last   = (({1'b0, r_step} + c_lw'(1)) >= seq_len) || (r_step == c_last_idx);

    always_comb begin
        w_state_nxt = r_state;
        w_speed_nxt = r_speed;
        w_step_nxt  = r_step;
        w_dwell_nxt = r_dwell;
        w_load      = 1'b0;
        w_load_idx  = '0;
        w_tick_clr  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (start && w_len_ok) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                    w_tick_clr  = 1'b1;
                end
            end
            RUN: begin
                if (w_tick) begin
                    if (r_dwell != DUR_W'(1)) begin
                        w_dwell_nxt = r_dwell - DUR_W'(1);
                    end else if (!w_last) begin
                        w_load     = 1'b1;
                        w_load_idx = r_step + c_aw'(1);
                    end else if (loop) begin
                        w_load     = 1'b1;
                    end else begin
                        w_state_nxt = FINISH;
                        w_speed_nxt = '0;
                        w_step_nxt  = '0;
                        w_dwell_nxt = '0;
                    end
                end
            end
            FINISH: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        w_entry = r_table[w_load_idx];
        if (w_load) begin
            w_speed_nxt = SPEED_W'(w_entry.speed);
            w_step_nxt  = w_load_idx;
            w_dwell_nxt = (w_entry.dur == '0) ? DUR_W'(1) : DUR_W'(w_entry.dur);
        end

        // Abort wins over everything, including a simultaneous start.
        if (stop) begin
            w_state_nxt = IDLE;
            w_speed_nxt = '0;
            w_step_nxt  = '0;
            w_dwell_nxt = '0;
            w_tick_clr  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_speed <= '0;
            r_step  <= '0;
            r_dwell <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_speed <= w_speed_nxt;
            r_step  <= w_step_nxt;
            r_dwell <= w_dwell_nxt;
        end
    end

    assign speed = r_speed;
    assign step  = r_step;
    assign busy  = (r_state == RUN);
    assign done  = (r_state == FINISH);

endmodule

`default_nettype wire

// File: tb/tb_blink_sequencer.sv
// ============================================================================
// Module   : tb_blink_sequencer
// Brief    : Scoreboard bench for blink_sequencer with TICK_DIV = 4.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_blink_sequencer;

    localparam int c_depth = 8;
    localparam int c_td    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_speed = '0;
    logic [15:0] cfg_dur = '0;
    logic [3:0]  seq_len = '0;
    logic        loop = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] speed;
    logic [2:0]  step;
    logic        busy;
    logic        done;

    blink_sequencer #(
        .DEPTH    (c_depth),
        .SPEED_W  (16),
        .DUR_W    (16),
        .TICK_DIV (c_td)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_speed (cfg_speed),
        .cfg_dur   (cfg_dur),
        .seq_len   (seq_len),
        .loop      (loop),
        .start     (start),
        .stop      (stop),
        .speed     (speed),
        .step      (step),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          cyc;
        logic [15:0] spd;
        logic [2:0]  stp;
        logic        bsy;
        logic        dn;
    } ev_t;

    ev_t   exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    logic [20:0] last_obs = '0;

    // Output-change monitor: each change must match the oldest expected event.
    always @(negedge clk) begin
        logic [20:0] cur;
        ev_t   e;
        string n;
        cur = {speed, step, busy, done};
        if (mon_en) begin
            if (cur != last_obs) begin
                last_obs = cur;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: cyc=%0d speed=%0d step=%0d busy=%0b done=%0b, required no change",
                             cyc, speed, step, busy, done);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    if (e.cyc != cyc || {e.spd, e.stp, e.bsy, e.dn} != cur) begin
                        errors++;
                        $display("FAIL %s: actual cyc=%0d speed=%0d step=%0d busy=%0b done=%0b, required cyc=%0d speed=%0d step=%0d busy=%0b done=%0b",
                                 n, cyc, speed, step, busy, done, e.cyc, e.spd, e.stp, e.bsy, e.dn);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                checks++;
                errors++;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                $display("FAIL %s: no output change at cyc=%0d (speed=%0d step=%0d busy=%0b done=%0b), required speed=%0d step=%0d busy=%0b done=%0b",
                         n, cyc, speed, step, busy, done, e.spd, e.stp, e.bsy, e.dn);
            end
        end
    end

    task automatic push(input string n, input int c, input int spd, input int stp,
                        input bit b, input bit d);
        ev_t e;
        e.cyc = c;
        e.spd = 16'(spd);
        e.stp = 3'(stp);
        e.bsy = b;
        e.dn  = d;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic chk(input string n, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", n, act, req);
        end
    endtask

    task automatic wr(input int a, input int s, input int d);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = 3'(a);
        cfg_speed = 16'(s);
        cfg_dur   = 16'(d);
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic at_cyc(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic quiet(input string n);
        repeat (3) @(negedge clk);
        chk(n, exp_q.size(), 0);
    endtask

    task automatic load_base_table();
        wr(0, 5, 2);
        wr(1, 9, 1);
        wr(2, 3, 3);
    endtask

    task automatic push_base_run(input string p, input int t0);
        push({p, "_e0"},   t0,      5, 0, 1'b1, 1'b0);
        push({p, "_e1"},   t0 + 8,  9, 1, 1'b1, 1'b0);
        push({p, "_e2"},   t0 + 12, 3, 2, 1'b1, 1'b0);
        push({p, "_done"}, t0 + 24, 0, 0, 1'b0, 1'b1);
        push({p, "_idle"}, t0 + 25, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {speed, step, busy, done}, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Plain three-entry run to completion.
        load_base_table();
        seq_len = 4'd3;
        loop    = 1'b0;
        @(negedge clk);
        t0 = cyc + 1;
        push_base_run("t1", t0);
        pulse_start();
        at_cyc(t0 + 28);
        quiet("t1_end");

        // Looping run, wrap without gap, then abort.
        loop = 1'b1;
        @(negedge clk);
        t0 = cyc + 1;
        push("t2_e0",   t0,      5, 0, 1'b1, 1'b0);
        push("t2_e1",   t0 + 8,  9, 1, 1'b1, 1'b0);
        push("t2_e2",   t0 + 12, 3, 2, 1'b1, 1'b0);
        push("t2_wrap", t0 + 24, 5, 0, 1'b1, 1'b0);
        push("t2_e1b",  t0 + 32, 9, 1, 1'b1, 1'b0);
        pulse_start();
        at_cyc(t0 + 33);
        push("t2_stop", t0 + 34, 0, 0, 1'b0, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        quiet("t2_end");

        // Ignored starts.
        loop = 1'b0;
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        quiet("t3_start_stop");
        seq_len = 4'd0;
        pulse_start();
        quiet("t3_len0");
        seq_len = 4'd9;
        pulse_start();
        quiet("t3_len9");

        // dur=0 behaves as 1; rewrite of the playing entry waits for reload.
        wr(0, 7, 0);
        wr(1, 9, 1);
        seq_len = 4'd2;
        loop    = 1'b1;
        @(negedge clk);
        t0 = cyc + 1;
        push("t4_e0",    t0,      7, 0, 1'b1, 1'b0);
        push("t4_e1",    t0 + 4,  9, 1, 1'b1, 1'b0);
        push("t4_e0new", t0 + 8,  6, 0, 1'b1, 1'b0);
        push("t4_e1b",   t0 + 12, 9, 1, 1'b1, 1'b0);
        pulse_start();
        wr(0, 6, 0);
        at_cyc(t0 + 13);
        push("t4_stop", t0 + 14, 0, 0, 1'b0, 1'b0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        quiet("t4_end");

        // Asynchronous reset mid entry 1, then replay of a cleared table.
        load_base_table();
        seq_len = 4'd3;
        loop    = 1'b0;
        @(negedge clk);
        t0 = cyc + 1;
        push("t5_e0", t0,     5, 0, 1'b1, 1'b0);
        push("t5_e1", t0 + 8, 9, 1, 1'b1, 1'b0);
        pulse_start();
        at_cyc(t0 + 9);
        #2;
        push("t5_rst", cyc + 1, 0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_immediate", {speed, step, busy, done}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        t0 = cyc + 1;
        push("t5_c0",    t0,      0, 0, 1'b1, 1'b0);
        push("t5_c1",    t0 + 4,  0, 1, 1'b1, 1'b0);
        push("t5_c2",    t0 + 8,  0, 2, 1'b1, 1'b0);
        push("t5_cdone", t0 + 12, 0, 0, 1'b0, 1'b1);
        push("t5_cidle", t0 + 13, 0, 0, 1'b0, 1'b0);
        pulse_start();
        at_cyc(t0 + 16);
        quiet("t5_end");

        // start while running is ignored.
        load_base_table();
        @(negedge clk);
        t0 = cyc + 1;
        push_base_run("t6", t0);
        pulse_start();
        at_cyc(t0 + 5);
        pulse_start();
        at_cyc(t0 + 9);
        pulse_start();
        at_cyc(t0 + 28);
        quiet("t6_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/blink_sequencer.md
# blink_sequencer

- Plays a programmed sequence of blink rates. Each table entry holds a blink period and a dwell time in milliseconds.
- Drives the `speed` input of a `blink_controller` instance, which sits beside it under the board top.
- Top-level glue or a register interface loads the table and issues start/stop.
- Has its own millisecond timebase, so entry durations are independent of the blink period.

## Interface
- `DEPTH`, 8: number of table entries, 2..16.
- `SPEED_W`, 16: width of the blink-period field.
- `DUR_W`, 16: width of the dwell field, in ms.
- `TICK_DIV`, 100_000: clk cycles per ms tick, ≥ 2.
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cfg_we`  in  1: table write strobe.
- `cfg_addr`  in  $clog2(DEPTH): entry index.
- `cfg_speed`  in  SPEED_W: blink period for the entry.
- `cfg_dur`  in  DUR_W: dwell time in ms.
- `seq_len`  in  $clog2(DEPTH)+1: number of active entries, 1..DEPTH.
- `loop`  in  1: 1 = wrap to entry 0 after the last entry.
- `start`  in  1: single-cycle pulse that begins the sequence.
- `stop`  in  1: single-cycle pulse that aborts the sequence.
- `speed`  out  SPEED_W: to `blink_controller.speed`; 0 = LED held off.
- `step`  out  $clog2(DEPTH): index of the entry currently playing.
- `busy`  out  1: sequence running.
- `done`  out  1: one-cycle pulse on normal completion.

## Operation
- FSM states: `IDLE`, `RUN`, `FINISH`.
- `IDLE`
  - Outputs: `speed`=0, `step`=0, `busy`=0.
  - `start` with `stop`=0 and 1 ≤ `seq_len` ≤ DEPTH → `RUN`, loading entry 0.
  - `start` with `seq_len`=0 or `seq_len` > DEPTH is ignored.
- `RUN`
  - `speed` is the speed of the loaded entry, held in a register, not a live table read.
  - A dwell counter is loaded with `cfg_dur`; a value of 0 is treated as 1.
  - The dwell counter decrements on each ms tick.
  - On a tick while the dwell counter = 1:
    - if `step` < `seq_len`-1: `step`+1 and load the next entry;
    - else if `loop`=1: `step`=0 and load entry 0;
    - else go to `FINISH`.
  - `seq_len` and `loop` are sampled live.
  - If `seq_len` is reduced to ≤ `step`, the current entry is treated as the last one.
- `FINISH`: assert `done` for one cycle, drive `speed`=0, then go to `IDLE`.
- `stop` in any state → `IDLE` on the next edge. `done` is not asserted.
- `stop` beats `start` when both arrive in the same cycle.
- `start` while `busy`=1 is ignored; there is no restart.
- Table writes are accepted in every state.
  - A write to the entry currently playing takes effect only when that entry is next loaded.
  - Writes with `cfg_addr` ≥ DEPTH are dropped.
- Table contents after reset: every entry has speed=0 and dur=0.

## Timing
- Reset values: `speed`=0, `step`=0, `busy`=0, `done`=0, FSM=`IDLE`, prescaler=0, dwell=0.
- `start` sampled at edge N:
  - at N+1: `busy`=1, `step`=0, `speed`=entry0.speed;
  - the prescaler clears at the same edge.
- Dwell length: an entry with dur=D (D ≥ 1) holds `speed` for exactly D×TICK_DIV cycles.
- On the last tick of an entry, the next entry's `speed` and `step` appear at the following edge; there are no gap cycles.
- Completion after the last tick:
  - at +1: `done`=1, `busy`=0, `speed`=0;
  - at +2: `done`=0.
- `stop` at edge N: `busy`=0 and `speed`=0 at N+1.
- Reset mid-sequence clears all outputs immediately (asynchronous); the table is also cleared.
- A table write at edge N is readable by an entry load at edge N+1 or later.
- Counter widths:
  - prescaler: $clog2(TICK_DIV) bits, wrapping from TICK_DIV-1 to 0;
  - dwell counter: DUR_W bits, no overflow possible.

## Structure
- Package `blink_pkg`:
  - `seq_state_e` enum (`IDLE`, `RUN`, `FINISH`);
  - `seq_entry_t` struct {speed, dur};
  - default `TICK_DIV` constant.
- Sub-module `ms_tick_gen`:
  - ports: `clk`, `rst_n`, `clr`, `tick`;
  - parameter `TICK_DIV`;
  - one-cycle `tick` every TICK_DIV cycles; `clr` zeroes the count.
- The table is a flop array of `seq_entry_t` with a synchronous write port.

## Test plan
- Use TICK_DIV=4 throughout.
- Table {(5,2),(9,1),(3,3)}, `seq_len`=3, `loop`=0, `start` → `speed` sequence 5 for 8 cycles, 9 for 4 cycles, 3 for 12 cycles; `done` one cycle later with `speed`=0.
- Same table, `loop`=1 → after entry 2, `step`=0 and `speed`=5 with no gap; `done` never asserts; `stop` → `speed`=0 on the next cycle.
- `start` and `stop` asserted together in `IDLE` → `busy` stays 0. `start` with `seq_len`=0 → ignored.
- Entry dur=0 → holds for 4 cycles, same as dur=1. Rewriting entry 0 during entry 0 → new speed applies only on the next loop pass.
- Assert `rst_n` low mid-entry 1 → `speed`, `step`, `busy` are 0 immediately. A `start` after release plays entry 0 with speed 0.
- `start` pulsed during `RUN` → no restart; `step` and the dwell timing are unchanged.
